// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder: letter indices, symbol
// encoding, FSM states and the ITU code table lookup.
package morse_pkg;

    localparam logic [4:0] LTR_A = 5'd0;
    localparam logic [4:0] LTR_B = 5'd1;
    localparam logic [4:0] LTR_C = 5'd2;
    localparam logic [4:0] LTR_D = 5'd3;
    localparam logic [4:0] LTR_E = 5'd4;
    localparam logic [4:0] LTR_F = 5'd5;
    localparam logic [4:0] LTR_G = 5'd6;
    localparam logic [4:0] LTR_H = 5'd7;
    localparam logic [4:0] LTR_I = 5'd8;
    localparam logic [4:0] LTR_J = 5'd9;
    localparam logic [4:0] LTR_K = 5'd10;
    localparam logic [4:0] LTR_L = 5'd11;
    localparam logic [4:0] LTR_M = 5'd12;
    localparam logic [4:0] LTR_N = 5'd13;
    localparam logic [4:0] LTR_O = 5'd14;
    localparam logic [4:0] LTR_P = 5'd15;
    localparam logic [4:0] LTR_Q = 5'd16;
    localparam logic [4:0] LTR_R = 5'd17;
    localparam logic [4:0] LTR_S = 5'd18;
    localparam logic [4:0] LTR_T = 5'd19;
    localparam logic [4:0] LTR_U = 5'd20;
    localparam logic [4:0] LTR_V = 5'd21;
    localparam logic [4:0] LTR_W = 5'd22;
    localparam logic [4:0] LTR_X = 5'd23;
    localparam logic [4:0] LTR_Y = 5'd24;
    localparam logic [4:0] LTR_Z = 5'd25;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_EMIT
    } state_t;

    // Returns {hit, index}; symbol i sits in bits[i], unused bits are zero.
    function automatic logic [5:0] decode_symbols(input logic [2:0] len,
                                                  input logic [3:0] bits);
        logic [5:0] r;
        r = 6'd0;
        case ({len, bits})
            {3'd2, 4'b0010}: r = {1'b1, LTR_A};
            {3'd4, 4'b0001}: r = {1'b1, LTR_B};
            {3'd4, 4'b0101}: r = {1'b1, LTR_C};
            {3'd3, 4'b0001}: r = {1'b1, LTR_D};
            {3'd1, 4'b0000}: r = {1'b1, LTR_E};
            {3'd4, 4'b0100}: r = {1'b1, LTR_F};
            {3'd3, 4'b0011}: r = {1'b1, LTR_G};
            {3'd4, 4'b0000}: r = {1'b1, LTR_H};
            {3'd2, 4'b0000}: r = {1'b1, LTR_I};
            {3'd4, 4'b1110}: r = {1'b1, LTR_J};
            {3'd3, 4'b0101}: r = {1'b1, LTR_K};
            {3'd4, 4'b0010}: r = {1'b1, LTR_L};
            {3'd2, 4'b0011}: r = {1'b1, LTR_M};
            {3'd2, 4'b0001}: r = {1'b1, LTR_N};
            {3'd3, 4'b0111}: r = {1'b1, LTR_O};
            {3'd4, 4'b0110}: r = {1'b1, LTR_P};
            {3'd4, 4'b1011}: r = {1'b1, LTR_Q};
            {3'd3, 4'b0010}: r = {1'b1, LTR_R};
            {3'd3, 4'b0000}: r = {1'b1, LTR_S};
            {3'd1, 4'b0001}: r = {1'b1, LTR_T};
            {3'd3, 4'b0100}: r = {1'b1, LTR_U};
            {3'd4, 4'b1000}: r = {1'b1, LTR_V};
            {3'd3, 4'b0110}: r = {1'b1, LTR_W};
            {3'd4, 4'b1001}: r = {1'b1, LTR_X};
            {3'd4, 4'b1101}: r = {1'b1, LTR_Y};
            {3'd4, 4'b0011}: r = {1'b1, LTR_Z};
            default:         r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus tick-counted debounce for the Morse key;
// emits the debounced level and single-cycle rise/fall pulses.
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic key_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    // Any agreement between raw and debounced level restarts the stability count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_q2 == level) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt >= DB_LAST) begin
                    level  <= sync_q2;
                    rise   <= sync_q2;
                    fall   <= !sync_q2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morse_key_decoder.sv
// Times debounced key presses as dots/dashes, collects up to four symbols
// and decodes them into a held one-hot letter after a letter gap.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 8,
    parameter int DOT_MAX_TICKS  = 150,
    parameter int GAP_TICKS      = 450,
    parameter int CNT_W          = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        key_in,
    input  logic        clear,
    output logic [25:0] letter_onehot,
    output logic        letter_valid,
    output logic        decode_err,
    output logic [2:0]  sym_count,
    output logic [3:0]  sym_bits
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             overflow;
    logic             key_level;
    logic             key_rise;
    logic             key_fall;
    logic [5:0]       decoded;

    key_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .key_in (key_in),
        .level  (key_level),
        .rise   (key_rise),
        .fall   (key_fall)
    );

    assign decoded = decode_symbols(sym_count, sym_bits);

    // The letter is decoded on the tick that closes the gap, so the strobe is
    // visible during the single EMIT cycle that then clears the symbol store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            press_cnt     <= '0;
            gap_cnt       <= '0;
            overflow      <= 1'b0;
            sym_count     <= 3'd0;
            sym_bits      <= 4'd0;
            letter_onehot <= 26'd0;
            letter_valid  <= 1'b0;
            decode_err    <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            decode_err   <= 1'b0;
            if (clear) begin
                state         <= ST_IDLE;
                press_cnt     <= '0;
                gap_cnt       <= '0;
                overflow      <= 1'b0;
                sym_count     <= 3'd0;
                sym_bits      <= 4'd0;
                letter_onehot <= 26'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (key_rise) begin
                            state     <= ST_PRESS;
                            press_cnt <= '0;
                        end
                    end
                    ST_PRESS: begin
                        if (key_fall) begin
                            if (sym_count < 3'd4) begin
                                sym_bits[sym_count[1:0]] <= (press_cnt > DOT_MAX) ? SYM_DASH : SYM_DOT;
                                sym_count <= sym_count + 3'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end else if (tick && press_cnt != CNT_MAX) begin
                            press_cnt <= press_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (key_rise) begin
                            state     <= ST_PRESS;
                            press_cnt <= '0;
                        end else if (tick) begin
                            if (gap_cnt != CNT_MAX) begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                            if (gap_cnt >= GAP_LAST) begin
                                state <= ST_EMIT;
                                if (!overflow && decoded[5]) begin
                                    letter_onehot <= 26'd1 << decoded[4:0];
                                    letter_valid  <= 1'b1;
                                end else begin
                                    decode_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_EMIT: begin
                        sym_count <= 3'd0;
                        sym_bits  <= 4'd0;
                        overflow  <= 1'b0;
                        // A key that went down during this cycle starts the next letter.
                        if (key_level) begin
                            state     <= ST_PRESS;
                            press_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed self-checking bench for morse_key_decoder; one tick every four clocks.
module tb_morse_key_decoder;

    localparam logic [25:0] BIT_A = 26'h0000001;
    localparam logic [25:0] BIT_E = 26'h0000010;
    localparam logic [25:0] BIT_Q = 26'h0010000;
    localparam logic [25:0] BIT_T = 26'h0080000;
    localparam logic [25:0] BIT_W = 26'h0400000;

    logic        clk;
    logic        reset_n;
    logic        tick;
    logic        key_in;
    logic        clear;
    logic [25:0] letter_onehot;
    logic        letter_valid;
    logic        decode_err;
    logic [2:0]  sym_count;
    logic [3:0]  sym_bits;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;

    morse_key_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .key_in       (key_in),
        .clear        (clear),
        .letter_onehot(letter_onehot),
        .letter_valid (letter_valid),
        .decode_err   (decode_err),
        .sym_count    (sym_count),
        .sym_bits     (sym_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (letter_valid) valid_cnt++;
        if (decode_err) err_cnt++;
    end

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            do_tick();
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_key(input logic v);
        @(negedge clk) key_in = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press(input int n);
        set_key(1'b1);
        run_ticks(n);
        set_key(1'b0);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (letter_onehot !== 26'd0) begin
            errors++; $display("[TB] FAIL reset_onehot got %h expected %h", letter_onehot, 26'd0);
        end
        checks++;
        if ({letter_valid, decode_err} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_pulses got %b expected %b", {letter_valid, decode_err}, 2'b00);
        end
        checks++;
        if ({sym_count, sym_bits} !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_syms got %h expected %h", {sym_count, sym_bits}, 7'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_letter_a();
        int v0;
        v0 = valid_cnt;
        press(50);
        run_ticks(100);
        press(300);
        run_ticks(20);
        checks++;
        if ({sym_count, sym_bits} !== {3'd2, 4'b0010}) begin
            errors++; $display("[TB] FAIL a_syms got %h expected %h", {sym_count, sym_bits}, {3'd2, 4'b0010});
        end
        run_ticks(437);
        checks++;
        if (valid_cnt !== v0) begin
            errors++; $display("[TB] FAIL a_early got %0d expected %0d", valid_cnt, v0);
        end
        do_tick();
        checks++;
        if ({letter_valid, letter_onehot} !== {1'b1, BIT_A}) begin
            errors++; $display("[TB] FAIL a_emit got %h expected %h", {letter_valid, letter_onehot}, {1'b1, BIT_A});
        end
        @(negedge clk);
        checks++;
        if ({letter_valid, sym_count, letter_onehot} !== {1'b0, 3'd0, BIT_A}) begin
            errors++; $display("[TB] FAIL a_after got %h expected %h", {letter_valid, sym_count, letter_onehot}, {1'b0, 3'd0, BIT_A});
        end
        @(negedge clk);
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++; $display("[TB] FAIL a_pulse_count got %0d expected %0d", valid_cnt, v0 + 1);
        end
    endtask

    task automatic test_q_then_e();
        press(300); run_ticks(100);
        press(300); run_ticks(100);
        press(50);  run_ticks(100);
        press(300); run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_Q) begin
            errors++; $display("[TB] FAIL q_onehot got %h expected %h", letter_onehot, BIT_Q);
        end
        press(50); run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_E) begin
            errors++; $display("[TB] FAIL e_onehot got %h expected %h", letter_onehot, BIT_E);
        end
    endtask

    task automatic test_dot_dash_boundary();
        press(150); run_ticks(20);
        checks++;
        if ({sym_count, sym_bits} !== {3'd1, 4'b0000}) begin
            errors++; $display("[TB] FAIL press150_dot got %h expected %h", {sym_count, sym_bits}, {3'd1, 4'b0000});
        end
        press(151); run_ticks(20);
        checks++;
        if ({sym_count, sym_bits} !== {3'd2, 4'b0010}) begin
            errors++; $display("[TB] FAIL press151_dash got %h expected %h", {sym_count, sym_bits}, {3'd2, 4'b0010});
        end
        // Long enough that a wrapping 12-bit counter would land back at 100 (a dot).
        press(4196); run_ticks(20);
        checks++;
        if ({sym_count, sym_bits} !== {3'd3, 4'b0110}) begin
            errors++; $display("[TB] FAIL press_sat_dash got %h expected %h", {sym_count, sym_bits}, {3'd3, 4'b0110});
        end
        run_ticks(450);
        checks++;
        if (letter_onehot !== BIT_W) begin
            errors++; $display("[TB] FAIL w_onehot got %h expected %h", letter_onehot, BIT_W);
        end
    endtask

    task automatic test_overflow();
        int v0;
        for (int i = 0; i < 4; i++) begin
            press(50); run_ticks(100);
        end
        checks++;
        if ({sym_count, sym_bits} !== {3'd4, 4'b0000}) begin
            errors++; $display("[TB] FAIL four_dots got %h expected %h", {sym_count, sym_bits}, {3'd4, 4'b0000});
        end
        v0 = valid_cnt;
        press(50); run_ticks(20);
        checks++;
        if ({sym_count, sym_bits} !== {3'd4, 4'b0000}) begin
            errors++; $display("[TB] FAIL fifth_dot got %h expected %h", {sym_count, sym_bits}, {3'd4, 4'b0000});
        end
        run_ticks(437);
        do_tick();
        checks++;
        if ({decode_err, letter_valid, letter_onehot} !== {2'b10, BIT_W}) begin
            errors++; $display("[TB] FAIL overflow_err got %h expected %h", {decode_err, letter_valid, letter_onehot}, {2'b10, BIT_W});
        end
        @(negedge clk);
        checks++;
        if ({decode_err, valid_cnt} !== {1'b0, v0}) begin
            errors++; $display("[TB] FAIL overflow_after got %h expected %h", {decode_err, valid_cnt}, {1'b0, v0});
        end
        press(300); run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_T) begin
            errors++; $display("[TB] FAIL after_err_t got %h expected %h", letter_onehot, BIT_T);
        end
    endtask

    task automatic test_glitch();
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int k = 1; k <= 7; k++) begin
            set_key(1'b1); run_ticks(k);
            set_key(1'b0); run_ticks(2);
        end
        run_ticks(10);
        checks++;
        if ({sym_count, valid_cnt, err_cnt, letter_onehot} !== {3'd0, v0, e0, BIT_T}) begin
            errors++; $display("[TB] FAIL idle_glitch got %0d/%0d/%0d/%h expected 0/%0d/%0d/%h",
                               sym_count, valid_cnt, err_cnt, letter_onehot, v0, e0, BIT_T);
        end
        press(50); run_ticks(50);
        set_key(1'b1); run_ticks(7);
        set_key(1'b0); run_ticks(20);
        checks++;
        if (sym_count !== 3'd1) begin
            errors++; $display("[TB] FAIL gap_glitch_count got %0d expected %0d", sym_count, 1);
        end
        run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_E) begin
            errors++; $display("[TB] FAIL gap_glitch_letter got %h expected %h", letter_onehot, BIT_E);
        end
    endtask

    task automatic test_reset_mid_press();
        int v0;
        int e0;
        press(50);  run_ticks(100);
        press(300); run_ticks(100);
        set_key(1'b1); run_ticks(50);
        checks++;
        if (sym_count !== 3'd2) begin
            errors++; $display("[TB] FAIL pre_reset_count got %0d expected %0d", sym_count, 2);
        end
        @(negedge clk) reset_n = 1'b0;
        #1;
        checks++;
        if ({letter_onehot, letter_valid, decode_err, sym_count, sym_bits} !== 35'd0) begin
            errors++; $display("[TB] FAIL async_reset got %h expected %h",
                               {letter_onehot, letter_valid, decode_err, sym_count, sym_bits}, 35'd0);
        end
        set_key(1'b0);
        @(negedge clk) reset_n = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        run_ticks(470);
        checks++;
        if ({valid_cnt, err_cnt, sym_count} !== {v0, e0, 3'd0}) begin
            errors++; $display("[TB] FAIL post_reset_quiet got %0d/%0d/%0d expected %0d/%0d/0",
                               valid_cnt, err_cnt, sym_count, v0, e0);
        end
    endtask

    task automatic test_clear_held();
        int v0;
        int e0;
        press(300); run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_T) begin
            errors++; $display("[TB] FAIL pre_clear_t got %h expected %h", letter_onehot, BIT_T);
        end
        press(50); run_ticks(100);
        set_key(1'b1); run_ticks(50);
        checks++;
        if (sym_count !== 3'd1) begin
            errors++; $display("[TB] FAIL pre_clear_count got %0d expected %0d", sym_count, 1);
        end
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        checks++;
        if ({letter_onehot, sym_count, sym_bits} !== 33'd0) begin
            errors++; $display("[TB] FAIL clear_zero got %h expected %h", {letter_onehot, sym_count, sym_bits}, 33'd0);
        end
        v0 = valid_cnt;
        e0 = err_cnt;
        set_key(1'b0); run_ticks(30);
        checks++;
        if (sym_count !== 3'd0) begin
            errors++; $display("[TB] FAIL clear_release got %0d expected %0d", sym_count, 0);
        end
        run_ticks(470);
        checks++;
        if ({valid_cnt, err_cnt} !== {v0, e0}) begin
            errors++; $display("[TB] FAIL clear_quiet got %0d/%0d expected %0d/%0d", valid_cnt, err_cnt, v0, e0);
        end
        press(50); run_ticks(470);
        checks++;
        if (letter_onehot !== BIT_E) begin
            errors++; $display("[TB] FAIL clear_next_e got %h expected %h", letter_onehot, BIT_E);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        reset_n   = 1'b0;
        tick      = 1'b0;
        key_in    = 1'b0;
        clear     = 1'b0;
        test_reset();
        test_letter_a();
        test_q_then_e();
        test_dot_dash_boundary();
        test_overflow();
        test_glitch();
        test_reset_mid_press();
        test_clear_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
